// File: rtl/i2c_slave_regfile.sv
// I2C slave with a byte-wide register file, running entirely on the system clock.
// SCL/SDA are oversampled through 2-FF synchronisers; START/STOP and SCL edges are
// detected from the synchronised samples and their one-cycle history.
//
// Ports:
//   clk        system clock (>= 10x SCL)
//   rst_n      asynchronous active-low reset
//   scl_i      SCL pad input (asynchronous)
//   sda_i      SDA pad input (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   regs_flat  register file, register k at bits [8k+7:8k]
//   wr_strobe  one-clk pulse when a data byte is written
//   wr_index   register index written, valid with wr_strobe
//   busy       high from START until STOP
//   stop_seen  one-clk pulse on STOP
module i2c_slave_regfile #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h06,
    parameter int unsigned REG_DEPTH  = 8,
    localparam int unsigned PTR_W     = (REG_DEPTH > 2) ? $clog2(REG_DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   sda_oe,
    output logic [8*REG_DEPTH-1:0] regs_flat,
    output logic                   wr_strobe,
    output logic [PTR_W-1:0]       wr_index,
    output logic                   busy,
    output logic                   stop_seen
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             stop_q, stop_d;
    logic             wr_en_q, wr_en_d;
    logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]       regs_q [REG_DEPTH];

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic       ptr_ok;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    // SCL must be high in both samples, so a simultaneous SCL/SDA change is data
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    assign rx_byte = {shreg_q[6:0], sda_s};
    assign ptr_ok  = {1'b0, rx_byte} < 9'(REG_DEPTH);
    assign ptr_inc = (ptr_q == PTR_W'(REG_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        stop_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            stop_d    = 1'b1;
        end else begin
            case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == StAddr) begin
                                state_d = (rx_byte[7:1] == SLAVE_ADDR) ? StAddrAck : StIgnore;
                            end else if (state_q == StPtr) begin
                                if (ptr_ok) begin
                                    ptr_d   = rx_byte[PTR_W-1:0];
                                    state_d = StPtrAck;
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else begin
                                wr_en_d  = 1'b1;
                                wr_idx_d = ptr_q;
                                state_d  = StWdataAck;
                            end
                        end
                    end
                end
                // sda_oe doubles as the ACK-slot phase: first fall drives, second releases
                StAddrAck, StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == StAddrAck) begin
                                if (shreg_q[0]) begin
                                    state_d  = StRdata;
                                    shreg_d  = regs_q[ptr_q];
                                    sda_oe_d = ~regs_q[ptr_q][7];
                                end else begin
                                    state_d = StPtr;
                                end
                            end else begin
                                state_d = StWdata;
                                if (state_q == StWdataAck) ptr_d = ptr_inc;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StRdataAck;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_oe_d  = ~shreg_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                // Entered on a fall, so the next fall always follows the ACK rise
                StRdataAck: begin
                    if (scl_rise) begin
                        ptr_d = ptr_inc;
                        if (sda_s) state_d = StIgnore;
                    end else if (scl_fall) begin
                        state_d   = StRdata;
                        bit_cnt_d = '0;
                        shreg_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            for (int k = 0; k < int'(REG_DEPTH); k++) regs_q[k] <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            stop_q     <= stop_d;
            wr_en_q    <= wr_en_d;
            wr_idx_q   <= wr_idx_d;
            if (wr_en_d) regs_q[wr_idx_d] <= rx_byte;
        end
    end

    for (genvar k = 0; k < int'(REG_DEPTH); k++) begin : g_flat
        assign regs_flat[8*k +: 8] = regs_q[k];
    end

    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_en_q;
    assign wr_index  = wr_idx_q;
    assign busy      = busy_q;
    assign stop_seen = stop_q;

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Next-generation I2C slave that runs entirely in the system clock domain and oversamples SCL/SDA through synchronisers.
- Supports a parametrised 7-bit address, a byte-wide register file of parametrised depth and an auto-incrementing register pointer.
- Handles multi-byte writes, multi-byte reads and repeated START, and reports STOP.
- Sits behind the pad open-drain buffers; exposes register contents and write strobes to the local logic.

Parameters:
- SLAVE_ADDR, 7'h06, 7-bit bus address this slave responds to.
- REG_DEPTH, 8, number of 8-bit registers; must be 2..256.
- PTR_W, clog2(REG_DEPTH) (minimum 1), register pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; must be at least 10x SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release (open drain).
- regs_flat  out  8*REG_DEPTH  register file; register k occupies bits [8k+7:8k].
- wr_strobe  out  1  one-clk pulse when a data byte is written to the register file.
- wr_index  out  PTR_W  register index written; valid with wr_strobe.
- busy  out  1  high from START until STOP.
- stop_seen  out  1  one-clk pulse on STOP detection.

Behaviour:
- Reset (async, rst_n=0):
  - sda_oe=0, busy=0, wr_strobe=0, stop_seen=0, wr_index=0.
  - Every register = 0, pointer = 0, state = IDLE, bit counter = 0.
  - Reset mid-transfer releases SDA immediately; after release the block ignores the bus until the next START.
- Input sampling:
  - 2-FF synchroniser on each of scl_i and sda_i, plus one history flop each.
  - All edges are detected from the synchronised values.
- START: SDA 1->0 while SCL was high in both the current and the previous sample. STOP: SDA 1->0 replaced by 1->0's opposite, SDA 0->1, under the same SCL condition.
- START or STOP overrides every state:
  - START -> ADDR, bit counter cleared, sda_oe=0, busy=1.
  - STOP -> IDLE, sda_oe=0, busy=0, stop_seen pulse.
  - The pointer is kept across both.
- Bit timing:
  - SDA is sampled on the detected SCL rise.
  - sda_oe changes only on the detected SCL fall.
  - Bytes are MSB first; the 9th clock is ACK/NACK.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR:
  - Shift 8 bits.
  - Upper 7 bits == SLAVE_ADDR: drive ACK (sda_oe=1 from the fall after bit 8 to the fall after bit 9).
    - R/W=0 -> PTR.
    - R/W=1 -> RDATA.
  - Mismatch: no ACK, go to IGNORE.
- PTR (write transfer only):
  - First byte after the address.
  - Value < REG_DEPTH: load pointer, ACK, go to WDATA.
  - Otherwise: NACK (SDA released), go to IGNORE, pointer unchanged.
- WDATA:
  - On the 8th rise: regs[ptr] <= byte, wr_strobe=1 for one clk, wr_index=ptr.
  - ACK, then ptr <= ptr+1, wrapping REG_DEPTH-1 -> 0.
  - Returns to WDATA for further bytes; unlimited length.
- RDATA:
  - On the fall that ends the ACK slot (address or previous read ACK), load shifter with regs[ptr].
  - Drive bit 7 low/high via sda_oe = ~bit.
  - Shift on each subsequent fall.
  - After 8 bits release SDA for RDATA_ACK.
- RDATA_ACK (sampled on the 9th rise):
  - 0 (master ACK): ptr <= ptr+1 with wrap, next byte.
  - 1 (master NACK): pointer still increments, go to IGNORE with SDA released.
- Read after write:
  - Read uses the pointer left by the last write/read.
  - A repeated START after PTR gives the standard combined "set pointer, read" format.
- IGNORE: sda_oe=0; exits only on START or STOP.
- Simultaneous SCL and SDA change in one clk sample: not START/STOP; treated as a data transition.
- A wr_strobe pulse never coincides with reset; registers are not written for incomplete bytes (START/STOP mid-byte discards the partial byte).

Test Plan:
- Write: START, 0x0C, ptr 0x02, data 0xA5, 0x3C, STOP -> ACK on all four bytes; reg2=0xA5, reg3=0x3C; wr_strobe twice with wr_index 2,3; stop_seen pulses; busy low after.
- Combined read: START 0x0C, ptr 0x06, repeated START 0x0D, read three bytes (ACK, ACK, NACK), STOP -> returns reg6, reg7, reg0 (wrap); pointer ends at 1.
- Address mismatch: START 0x0E, 0xFF, STOP -> sda_oe never asserted; no wr_strobe; registers unchanged.
- Bad pointer: START 0x0C, ptr 0x08 (REG_DEPTH=8) -> NACK on pointer; following byte 0x55 not written and not ACKed.
- Wrap write: ptr 0x07, data 0x11, 0x22 -> reg7=0x11, reg0=0x22.
- Reset while driving read bit 0: rst_n low -> sda_oe=0 same cycle; registers 0; bus activity ignored until a fresh START; a subsequent write succeeds.
